// File: rtl/pps_gen.sv
// -----------------------------------------------------------------------------
// pps_gen -- programmable pulse-per-second generator with host registers.
//
// A free-running cycle counter (COUNT) runs from 0 up to a terminal value and
// then wraps. Each wrap starts a new second: SECOND increments, a one-cycle
// pps_latch strobe fires and a WIDTH-cycle active pulse begins. The terminal
// is normally the shadowed PERIOD, optionally offset once by a signed ADJUST.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset
//   pps_cs     register chip select
//   pps_wr     host write strobe (qualified by pps_cs)
//   pps_rd     host read strobe (qualified by pps_cs)
//   pps_addr   DWORD register address
//   pps_d4wt   host write data
//   pps_d4rd   host read data, combinational, 0 unless pps_cs & pps_rd
//   pps_pulse  registered PPS output, polarity from CTRL[1]
//   pps_latch  registered one-cycle strobe on each wrap
//
// Register map (DWORD addresses)
//   0x00 CTRL   [0] enable, [1] invert, [16] adjust_pending (RO)
//   0x01 PERIOD clocks per second minus 1
//   0x02 WIDTH  pulse width in clocks (24 bits)
//   0x03 ADJUST signed 16-bit one-shot correction (WO, reads 0)
//   0x04 COUNT  current cycle counter (RO)
//   0x05 SECOND seconds counter
// -----------------------------------------------------------------------------
module pps_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        pps_cs,
    input  logic        pps_wr,
    input  logic        pps_rd,
    input  logic [4:0]  pps_addr,
    input  logic [31:0] pps_d4wt,
    output logic [31:0] pps_d4rd,
    output logic        pps_pulse,
    output logic        pps_latch
);

    localparam logic [4:0] A_CTRL   = 5'd0;
    localparam logic [4:0] A_PERIOD = 5'd1;
    localparam logic [4:0] A_WIDTH  = 5'd2;
    localparam logic [4:0] A_ADJUST = 5'd3;
    localparam logic [4:0] A_COUNT  = 5'd4;
    localparam logic [4:0] A_SECOND = 5'd5;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q,      state_d;
    logic               invert_q,     invert_d;
    logic [31:0]        period_q,     period_d;
    logic [31:0]        act_period_q, act_period_d;
    logic [23:0]        width_q,      width_d;
    logic [23:0]        width_cnt_q,  width_cnt_d;
    logic signed [15:0] adjust_q,     adjust_d;
    logic               adj_pend_q,   adj_pend_d;
    logic [31:0]        cnt_q,        cnt_d;
    logic [31:0]        second_q,     second_d;
    logic               pulse_q,      pulse_d;
    logic               latch_q,      latch_d;

    logic               host_wr;
    logic               en_next;
    logic [33:0]        adj_sum;
    logic [33:0]        terminal;
    logic               wrap;

    // Terminal count: the adjusted sum is kept two bits wider than the period
    // so that its sign bit is never confused with a large positive period.
    // A negative or too-short adjusted second is clamped to WIDTH.
    always_comb begin
        adj_sum  = {2'b00, act_period_q} + {{18{adjust_q[15]}}, adjust_q};
        terminal = {2'b00, act_period_q};
        if (adj_pend_q) begin
            if (adj_sum[33] || (adj_sum[32:0] < {9'd0, width_q})) begin
                terminal = {10'd0, width_q};
            end else begin
                terminal = adj_sum;
            end
        end
    end

    always_comb begin
        host_wr = pps_cs & pps_wr;
        en_next = (host_wr && pps_addr == A_CTRL) ? pps_d4wt[0] : (state_q == RUN);
        // A disabling write suppresses the wrap that would otherwise coincide.
        wrap    = (state_q == RUN) && en_next && ({2'b00, cnt_q} == terminal);

        state_d      = en_next ? RUN : IDLE;
        invert_d     = invert_q;
        period_d     = period_q;
        act_period_d = act_period_q;
        width_d      = width_q;
        width_cnt_d  = width_cnt_q;
        adjust_d     = adjust_q;
        adj_pend_d   = adj_pend_q;
        cnt_d        = cnt_q;
        second_d     = second_q;
        latch_d      = 1'b0;

        if (!en_next) begin
            cnt_d       = '0;
            width_cnt_d = '0;
        end else if (state_q == IDLE) begin
            cnt_d        = '0;
            act_period_d = period_q;
        end else if (wrap) begin
            cnt_d        = '0;
            width_cnt_d  = width_q;
            latch_d      = 1'b1;
            act_period_d = period_q;
            adj_pend_d   = 1'b0;
            second_d     = second_q + 32'd1;
        end else begin
            cnt_d = cnt_q + 32'd1;
            if (width_cnt_q != '0) begin
                width_cnt_d = width_cnt_q - 24'd1;
            end
        end

        // Host writes come last so they win over wrap-time updates
        // (SECOND load beats increment, new ADJUST survives the wrap).
        if (host_wr) begin
            case (pps_addr)
                A_CTRL:   invert_d = pps_d4wt[1];
                A_PERIOD: period_d = pps_d4wt;
                A_WIDTH:  width_d  = pps_d4wt[23:0];
                A_ADJUST: begin
                    adjust_d   = $signed(pps_d4wt[15:0]);
                    adj_pend_d = 1'b1;
                end
                A_SECOND: second_d = pps_d4wt;
                default:  ;
            endcase
        end

        pulse_d = (width_cnt_d != '0) ^ invert_d;
    end

    // State register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            invert_q     <= 1'b0;
            period_q     <= '0;
            act_period_q <= '0;
            width_q      <= '0;
            width_cnt_q  <= '0;
            adjust_q     <= '0;
            adj_pend_q   <= 1'b0;
            cnt_q        <= '0;
            second_q     <= '0;
            pulse_q      <= 1'b0;
            latch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            invert_q     <= invert_d;
            period_q     <= period_d;
            act_period_q <= act_period_d;
            width_q      <= width_d;
            width_cnt_q  <= width_cnt_d;
            adjust_q     <= adjust_d;
            adj_pend_q   <= adj_pend_d;
            cnt_q        <= cnt_d;
            second_q     <= second_d;
            pulse_q      <= pulse_d;
            latch_q      <= latch_d;
        end
    end

    assign pps_pulse = pulse_q;
    assign pps_latch = latch_q;

    always_comb begin
        pps_d4rd = '0;
        if (pps_cs && pps_rd) begin
            case (pps_addr)
                A_CTRL:   pps_d4rd = {15'd0, adj_pend_q, 14'd0, invert_q, state_q == RUN};
                A_PERIOD: pps_d4rd = period_q;
                A_WIDTH:  pps_d4rd = {8'd0, width_q};
                A_COUNT:  pps_d4rd = cnt_q;
                A_SECOND: pps_d4rd = second_q;
                default:  pps_d4rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pps_gen.sv
module tb_pps_gen;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        cs    = 1'b0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic [4:0]  addr  = 5'd0;
    logic [31:0] d4wt  = 32'd0;
    logic [31:0] d4rd;
    logic        pulse;
    logic        latch;

    int tests = 0;
    int fails = 0;

    pps_gen dut (
        .clk      (clk),
        .rst      (rst),
        .pps_cs   (cs),
        .pps_wr   (wr),
        .pps_rd   (rd),
        .pps_addr (addr),
        .pps_d4wt (d4wt),
        .pps_d4rd (d4rd),
        .pps_pulse(pulse),
        .pps_latch(latch)
    );

    initial forever #5 clk = ~clk;

    // ---------------- behavioural model (time-stamp based) ----------------
    // Seconds are described by the cycle they started in; the pulse is
    // "active while fewer than WIDTH cycles have elapsed since the last wrap".
    longint cyc      = 0;
    bit     m_en     = 0;
    bit     m_inv    = 0;
    bit     m_pend   = 0;
    longint m_period = 0;
    longint m_width  = 0;
    longint m_adj    = 0;
    longint m_second = 0;
    longint m_act    = 0;
    longint m_start  = 0;
    bit     m_lwv    = 0;
    longint m_lw     = 0;
    longint m_ww     = 0;

    localparam longint MASK32 = 64'h0000_0000_FFFF_FFFF;

    function automatic longint m_term();
        longint t;
        t = m_act;
        if (m_pend) begin
            t = m_act + m_adj;
            if (t < m_width) t = m_width;
        end
        return t;
    endfunction

    function automatic longint m_read(input logic [4:0] a);
        case (a)
            5'd0:    return (longint'(m_pend) << 16) | (longint'(m_inv) << 1) | longint'(m_en);
            5'd1:    return m_period;
            5'd2:    return m_width;
            5'd4:    return m_en ? ((cyc - m_start) & MASK32) : 0;
            5'd5:    return m_second;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit     wen;
        bit     new_en;
        bit     wrap;
        longint cnt_now;
        if (rst) begin
            m_en = 0; m_inv = 0; m_pend = 0; m_period = 0; m_width = 0;
            m_adj = 0; m_second = 0; m_act = 0; m_lwv = 0;
        end else begin
            wen     = cs && wr;
            new_en  = (wen && addr == 5'd0) ? d4wt[0] : m_en;
            cnt_now = m_en ? (cyc - m_start) : 0;
            wrap    = m_en && new_en && (cnt_now == m_term());
            if (!new_en) m_lwv = 0;
            if (!m_en && new_en) begin
                m_start = cyc + 1;
                m_act   = m_period;
            end
            if (wrap) begin
                m_start  = cyc + 1;
                m_lw     = cyc + 1;
                m_lwv    = 1;
                m_ww     = m_width;
                m_second = (m_second + 1) & MASK32;
                m_act    = m_period;
                m_pend   = 0;
            end
            if (wen) begin
                case (addr)
                    5'd0: begin m_en = new_en; m_inv = d4wt[1]; end
                    5'd1: m_period = longint'(d4wt);
                    5'd2: m_width  = longint'(d4wt[23:0]);
                    5'd3: begin m_adj = longint'($signed(d4wt[15:0])); m_pend = 1; end
                    5'd5: m_second = longint'(d4wt);
                    default: ;
                endcase
            end
        end
        cyc = cyc + 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        longint exp_p;
        @(negedge clk);
        exp_p = ((m_lwv && (cyc - m_lw) < m_ww) ? 1 : 0) ^ longint'(m_inv);
        chk("pulse", longint'(pulse), exp_p);
        chk("latch", longint'(latch), (m_lwv && cyc == m_lw) ? 1 : 0);
        chk("rdata", longint'(d4rd), (cs && rd) ? m_read(addr) : 0);
    end

    // ---------------- stimulus helpers (start/end at posedge+1) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic hwr(input logic [4:0] a, input logic [31:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d4wt = v;
        step();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic hrd(input logic [4:0] a, output longint v);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        v = longint'(d4rd);
        step();
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_latch(input int limit, output longint at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (latch) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic count_high(input int n, output longint c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pulse) c++;
        end
    endtask

    task automatic count_latch(input int n, output longint c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (latch) c++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint v, e, n, t0, t1, t2;

        // Reset
        step();
        idle(2);
        chk("rst_pulse", longint'(pulse), 0);
        chk("rst_latch", longint'(latch), 0);
        hrd(5'd0, v); chk("rst_ctrl", v, 0);
        rst = 1'b0;
        step();
        hrd(5'd5, v); chk("rst_second", v, 0);

        // Basic: PERIOD=9, WIDTH=3
        hwr(5'd1, 32'd9);
        hwr(5'd2, 32'd3);
        hwr(5'd0, 32'd1);
        e = cyc;
        hrd(5'd4, v); chk("count_at_entry", v, 0);
        wait_latch(30, t1); chk("first_latch_latency", t1 - e, 10);
        hrd(5'd5, v); chk("second_1", v, 1);
        wait_latch(30, t2); chk("period_gap", t2 - t1, 10);
        hrd(5'd5, v); chk("second_2", v, 2);
        count_high(10, n); chk("pulse_width", n, 3);

        // Adjust +4: one second of 9+4+1 cycles, then back to 10
        wait_latch(30, t0);
        hwr(5'd3, 32'd4);
        hrd(5'd0, v); chk("adj_pending_set", v, 32'h0001_0001);
        wait_latch(40, t1); chk("adj_plus4_len", t1 - t0, 14);
        hrd(5'd0, v); chk("adj_pending_clr", v, 1);
        wait_latch(30, t2); chk("after_adj_len", t2 - t1, 10);
        // Adjust -20: clamped to WIDTH=3, second of 4 cycles
        hwr(5'd3, 32'h0000_FFEC);
        wait_latch(30, t1); chk("adj_clamp_len", t1 - t2, 4);
        wait_latch(30, t0); chk("after_clamp_len", t0 - t1, 10);
        // ADJUST=+2 written on the wrap edge applies to the following second
        idle(9);
        hwr(5'd3, 32'd2);
        wait_latch(40, t1); chk("adj_on_wrap_len", t1 - t0, 22);

        // Shadow: PERIOD=19 written at cnt=5
        wait_latch(30, t0);
        idle(4);
        hwr(5'd1, 32'd19);
        wait_latch(30, t1); chk("shadow_cur", t1 - t0, 10);
        wait_latch(40, t2); chk("shadow_next", t2 - t1, 20);
        hwr(5'd1, 32'd9);

        // WIDTH=0: latch keeps firing, pulse stays low
        hwr(5'd2, 32'd0);
        wait_latch(40, t0);
        wait_latch(30, t1); chk("w0_gap", t1 - t0, 10);
        count_high(10, n); chk("w0_pulse", n, 0);

        // WIDTH=12 > terminal: continuously active
        hwr(5'd2, 32'd12);
        wait_latch(30, t0);
        count_high(20, n); chk("w12_stuck", n, 20);

        // Invert
        hwr(5'd0, 32'd3);
        count_high(20, n); chk("inv_stuck", n, 0);
        hwr(5'd2, 32'd3);
        wait_latch(30, t0);
        count_high(10, n); chk("inv_width", n, 7);
        hwr(5'd0, 32'd1);

        // SECOND write on the wrap edge: host value wins
        wait_latch(30, t0);
        idle(9);
        hwr(5'd5, 32'd100);
        chk("latch_on_collision", longint'(latch), 1);
        hrd(5'd5, v); chk("second_write_wins", v, 100);
        wait_latch(30, t1);
        hrd(5'd5, v); chk("second_after_load", v, 101);

        // Disable mid-pulse
        wait_latch(30, t0);
        hwr(5'd0, 32'd0);
        chk("dis_pulse", longint'(pulse), 0);
        hrd(5'd4, v); chk("dis_count", v, 0);
        hrd(5'd5, v); chk("dis_second_kept", v, 102);

        // Reset mid-pulse, with a colliding CTRL write
        hwr(5'd0, 32'd1);
        wait_latch(30, t0);
        chk("pre_rst_pulse", longint'(pulse), 1);
        rst = 1'b1; cs = 1'b1; wr = 1'b1; addr = 5'd0; d4wt = 32'd3;
        step();
        rst = 1'b0; cs = 1'b0; wr = 1'b0;
        chk("mid_rst_pulse", longint'(pulse), 0);
        chk("mid_rst_latch", longint'(latch), 0);
        hrd(5'd0, v); chk("mid_rst_ctrl", v, 0);
        hrd(5'd1, v); chk("mid_rst_period", v, 0);
        hrd(5'd2, v); chk("mid_rst_width", v, 0);
        hrd(5'd5, v); chk("mid_rst_second", v, 0);
        hrd(5'd4, v); chk("mid_rst_count", v, 0);

        // PERIOD=0 after reset: latch every cycle
        hwr(5'd0, 32'd1);
        count_latch(5, n); chk("p0_latch_every_cycle", n, 5);
        hwr(5'd1, 32'd9);
        wait_latch(30, t0);
        wait_latch(30, t1); chk("reprog_gap", t1 - t0, 10);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
